// File: rtl/onehot_decoder_scan.sv
// ---------------------------------------------------------------------------
// onehot_decoder_scan
//
// Registered SEL_W-to-OUT_W one-hot decoder with a valid-qualified load,
// range checking and an auto-scan mode. In scan mode the active bit walks
// up or down and stays on each position for (dwell + 1) cycles. The block
// drives row/digit/channel selects from one registered source.
//
// Parameters:
//   SEL_W   - width of sel and idx
//   OUT_W   - number of one-hot outputs, legal range 1 .. 2**SEL_W
//   DWELL_W - width of the dwell setting and of the internal dwell counter
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   clear     in   synchronous clear to the idle state (idx kept)
//   in_valid  in   qualifies sel as a load this cycle
//   sel       in   index to decode
//   mode      in   00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD
//   dwell     in   cycles per scan position minus one
//   y         out  registered one-hot output, zero when idle
//   y_valid   out  high while y holds a one-hot value
//   idx       out  binary index of the active bit
//   range_err out  one-cycle pulse when an out-of-range sel is loaded
//   wrap      out  one-cycle pulse when a scan wraps around
// ---------------------------------------------------------------------------
module onehot_decoder_scan #(
  parameter int SEL_W   = 3,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [SEL_W-1:0]   sel,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [OUT_W-1:0]   y,
  output logic               y_valid,
  output logic [SEL_W-1:0]   idx,
  output logic               range_err,
  output logic               wrap
);

  localparam logic [1:0] MODE_DECODE    = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP   = 2'b01;
  localparam logic [1:0] MODE_SCAN_DOWN = 2'b10;
  localparam logic [1:0] MODE_HOLD      = 2'b11;

  // One extra bit so OUT_W == 2**SEL_W is representable in the range check.
  localparam logic [SEL_W:0]   OUT_W_L  = (SEL_W+1)'(OUT_W);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nx_s;
  logic [SEL_W-1:0]   idx_r;
  logic [SEL_W-1:0]   idx_nx_s;
  logic [DWELL_W-1:0] cnt_r;
  logic [DWELL_W-1:0] cnt_nx_s;
  logic [OUT_W-1:0]   y_r;
  logic [OUT_W-1:0]   y_nx_s;
  logic               y_valid_r;
  logic               y_valid_nx_s;
  logic               range_err_r;
  logic               range_err_nx_s;
  logic               wrap_r;
  logic               wrap_nx_s;
  logic               sel_ok_s;
  logic               dwell_done_s;

  // Decode a binary index into an OUT_W-wide one-hot vector.
  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    for (int k = 0; k < OUT_W; k++) begin
      if (i == SEL_W'(k)) begin
        v[k] = 1'b1;
      end else begin
        v[k] = 1'b0;
      end
    end
    return v;
  endfunction

  // Load qualification and the dwell comparison used by both scan directions.
  always_comb begin
    sel_ok_s     = ({1'b0, sel} < OUT_W_L);
    // >= rather than == so that lowering dwell mid-position never stalls.
    dwell_done_s = (cnt_r >= dwell);
  end

  // Next-state logic: clear beats a load, a load beats the mode action.
  always_comb begin
    state_nx_s     = state_r;
    idx_nx_s       = idx_r;
    cnt_nx_s       = cnt_r;
    range_err_nx_s = 1'b0;
    wrap_nx_s      = 1'b0;

    if (clear) begin
      state_nx_s = ST_IDLE;
      cnt_nx_s   = {DWELL_W{1'b0}};
    end else if (in_valid) begin
      cnt_nx_s = {DWELL_W{1'b0}};
      if (sel_ok_s) begin
        state_nx_s = ST_ACTIVE;
        idx_nx_s   = sel;
      end else begin
        // Out-of-range load blanks the output but keeps the last index.
        state_nx_s     = ST_IDLE;
        range_err_nx_s = 1'b1;
      end
    end else if (state_r == ST_ACTIVE) begin
      case (mode)
        MODE_SCAN_UP: begin
          if (dwell_done_s) begin
            cnt_nx_s = {DWELL_W{1'b0}};
            if (idx_r == LAST_IDX) begin
              idx_nx_s  = {SEL_W{1'b0}};
              wrap_nx_s = 1'b1;
            end else begin
              idx_nx_s = idx_r + SEL_W'(1);
            end
          end else begin
            cnt_nx_s = cnt_r + DWELL_W'(1);
          end
        end
        MODE_SCAN_DOWN: begin
          if (dwell_done_s) begin
            cnt_nx_s = {DWELL_W{1'b0}};
            if (idx_r == {SEL_W{1'b0}}) begin
              idx_nx_s  = LAST_IDX;
              wrap_nx_s = 1'b1;
            end else begin
              idx_nx_s = idx_r - SEL_W'(1);
            end
          end else begin
            cnt_nx_s = cnt_r + DWELL_W'(1);
          end
        end
        MODE_DECODE: begin
          cnt_nx_s = cnt_r;
        end
        MODE_HOLD: begin
          cnt_nx_s = cnt_r;
        end
        default: begin
          cnt_nx_s = cnt_r;
        end
      endcase
    end else begin
      // Idle: scan modes do not start without a load.
      state_nx_s = ST_IDLE;
    end
  end

  // Output decode from the next state so y, y_valid and idx line up.
  always_comb begin
    if (state_nx_s == ST_ACTIVE) begin
      y_nx_s       = onehot(idx_nx_s);
      y_valid_nx_s = 1'b1;
    end else begin
      y_nx_s       = {OUT_W{1'b0}};
      y_valid_nx_s = 1'b0;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= {SEL_W{1'b0}};
      cnt_r       <= {DWELL_W{1'b0}};
      y_r         <= {OUT_W{1'b0}};
      y_valid_r   <= 1'b0;
      range_err_r <= 1'b0;
      wrap_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      idx_r       <= idx_nx_s;
      cnt_r       <= cnt_nx_s;
      y_r         <= y_nx_s;
      y_valid_r   <= y_valid_nx_s;
      range_err_r <= range_err_nx_s;
      wrap_r      <= wrap_nx_s;
    end
  end

  assign y         = y_r;
  assign y_valid   = y_valid_r;
  assign idx       = idx_r;
  assign range_err = range_err_r;
  assign wrap      = wrap_r;

endmodule

// File: doc/onehot_decoder_scan.md
Name: onehot_decoder_scan

Overview:
- Parametrised, registered N-to-OUT_W one-hot decoder.
- Generalises the combinational 3-to-8 decoder in width.
- Adds a valid-qualified load, range checking, and an auto-scan mode. In scan mode the active bit walks up or down with a programmable dwell time.
- Drives row/digit/channel selects (LED multiplex, keypad scan, mux enables) from one registered source.

Parameters:
- SEL_W, 3, width of the select input and of the idx output.
- OUT_W, 8, number of one-hot outputs; legal range 1 to 2**SEL_W.
- DWELL_W, 4, width of the dwell count; sets the maximum cycles per scan position.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous clear; forces the idle state.
- in_valid  input  1  qualifies sel for a load this cycle.
- sel  input  SEL_W  index to decode.
- mode  input  2  00 DECODE, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- dwell  input  DWELL_W  cycles per scan position minus 1.
- y  output  OUT_W  registered one-hot output; all zeros when idle.
- y_valid  output  1  high while y holds a one-hot value.
- idx  output  SEL_W  binary index of the active bit.
- range_err  output  1  one-cycle pulse when sel >= OUT_W is loaded.
- wrap  output  1  one-cycle pulse when a scan wraps around.

Behaviour:
- Reset (async): y=0, y_valid=0, idx=0, range_err=0, wrap=0, dwell counter cnt=0, state=IDLE.
- States:
  - IDLE: y=0, y_valid=0.
  - ACTIVE: y = 1<<idx, y_valid=1.
- All outputs are registered. Latency from input to y/idx/y_valid is 1 cycle.
- Per-cycle priority: clear > load (in_valid) > mode action.
- clear: next cycle state=IDLE, y=0, y_valid=0, cnt=0. idx is unchanged. range_err=0, wrap=0.
- Load with in_valid=1 and sel < OUT_W, in any mode including HOLD:
  - state=ACTIVE, idx=sel, y=1<<sel, cnt=0.
- Load with in_valid=1 and sel >= OUT_W:
  - state=IDLE, y=0, y_valid=0, cnt=0, idx unchanged.
  - range_err=1 for exactly one cycle.
- DECODE without load: all state holds; cnt does not count.
- SCAN_UP, ACTIVE, no load:
  - If cnt >= dwell: cnt=0 and idx advances.
    - If idx==OUT_W-1, idx=0 and wrap=1 for one cycle.
    - Otherwise idx=idx+1.
  - Else cnt=cnt+1.
- SCAN_DOWN: mirror of SCAN_UP. From idx==0, idx=OUT_W-1 and wrap=1.
- SCAN modes while IDLE: remain IDLE. A valid load is required to start a scan.
- HOLD: idx, cnt and state frozen. Only clear or a load changes them.
- dwell=0: position advances every cycle.
- Comparison is cnt >= dwell. Lowering dwell mid-position therefore advances on the next cycle and never stalls.
- Changing mode mid-dwell keeps cnt. The direction takes effect at the next advance.
- OUT_W=1: a scan advance keeps idx=0 and pulses wrap on every advance.
- range_err and wrap are 0 in every cycle not explicitly listed above.
- Invariants:
  - y is always zero or exactly one-hot.
  - y_valid equals the OR-reduction of y.
  - idx is always < OUT_W.
- Reset asserted mid-scan: outputs go to reset values immediately, without waiting for clk.
- After reset release the block stays IDLE until a load.

Test Plan:
- Decode sweep (SEL_W=3, OUT_W=8), mode=DECODE: load sel=0..7, one per cycle. One cycle later each y = 8'h01, 8'h02, ... 8'h80 with idx=sel and y_valid=1. Hold with in_valid=0 keeps the last value.
- Range error (OUT_W=6): load sel=3, then sel=6. Result: y=6'b001000, then y=0, y_valid=0, idx stays 3, range_err=1 for one cycle only.
- Scan up, dwell=2, load sel=6, then SCAN_UP:
  - Output sequence is idx 6,6,6,7,7,7,0,...
  - wrap=1 in the cycle idx becomes 0.
  - y=8'h01 at that point.
- Scan down, dwell=0, load sel=1:
  - idx sequence is 1,0,7,6 on consecutive cycles.
  - wrap pulses once, when idx goes 0 to 7.
- Priority and hold:
  - clear with in_valid=1 and sel=4 in the same cycle: IDLE, y=0.
  - Then load sel=2 with mode=HOLD: y=8'h04 and it holds for 10 cycles.
  - Then switch to SCAN_UP with dwell=1: idx becomes 3 two cycles later.
- Async reset mid-scan: assert rst between clock edges during SCAN_UP. y, idx, y_valid and wrap go to 0 before the next edge. After release, with mode=SCAN_UP and no load, the block stays IDLE.
